dac_spi_tx: RTL

DAC_SPI_TX -- requirements
Module: dac_spi_tx

---
 rtl/dac_spi_tx_pkg.sv | 45 ++++
 rtl/spi_clk_div.sv | 58 +++++
 rtl/dac_spi_tx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dac_spi_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_tx_pkg
//  Description : Shared constants, state encoding and sizing helper for the
//                DAC SPI frame transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dac_spi_tx_pkg;

    localparam int FRAME_BITS      = 32;
    localparam int DATA_FIELD_BITS = 12;

    localparam logic [3:0] DAC_CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0] DAC_ADDR_ALL         = 4'b1111;

    // Number of bits needed to hold 'value'; never less than one.
    function automatic int clogb2(input int value);
        int result;
        int v;
        result = 0;
        v      = value;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                result = result + 1;
                v      = v >> 1;
            end
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

    localparam int BIT_CNT_W = clogb2(FRAME_BITS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
//  Module      : spi_clk_div
//  Description : Serial clock timing; emits rise/fall strobes every CLK_DIV
//                cycles while run is high, starting from an SCK-low phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_div
    import dac_spi_tx_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic rise,
    output logic fall
);

    localparam int                 c_div_w    = clogb2(CLK_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

    logic [c_div_w-1:0] div_cnt_q;
    logic [c_div_w-1:0] div_cnt_d;
    logic               phase_q;
    logic               phase_d;
    logic               w_wrap;

    assign w_wrap = run && (div_cnt_q == c_div_last);
    assign rise   = w_wrap && !phase_q;
    assign fall   = w_wrap &&  phase_q;

    always_comb begin
        div_cnt_d = div_cnt_q;
        phase_d   = phase_q;
        if (!run) begin
            div_cnt_d = '0;
            phase_d   = 1'b0;
        end else if (w_wrap) begin
            div_cnt_d = '0;
            phase_d   = ~phase_q;
        end else begin
            div_cnt_d = div_cnt_q + c_div_w'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            phase_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dac_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_tx
//  Description : Periodic sample requester and 32-bit SPI frame transmitter
//                for a command/address/data DAC.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_spi_tx
    import dac_spi_tx_pkg::*;
#(
    parameter int         SIZE          = 12,
    parameter int         CLK_DIV       = 2,
    parameter int         SAMPLE_PERIOD = 200,
    parameter logic [3:0] DAC_CMD       = DAC_CMD_WRITE_UPDATE,
    parameter logic [3:0] DAC_ADDR      = DAC_ADDR_ALL
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [SIZE-1:0] data,
    output logic            next,
    output logic            spi_sck,
    output logic            spi_mosi,
    output logic            dac_cs_n,
    output logic            dac_clr_n,
    output logic            busy,
    output logic            overrun
);

    localparam int                   c_per_w    = clogb2(SAMPLE_PERIOD - 1);
    localparam logic [c_per_w-1:0]   c_per_last = c_per_w'(SAMPLE_PERIOD - 1);
    localparam int                   c_gap_w    = clogb2(2 * CLK_DIV - 1);
    localparam logic [c_gap_w-1:0]   c_gap_last = c_gap_w'(2 * CLK_DIV - 1);
    localparam logic [BIT_CNT_W-1:0] c_bit_last = BIT_CNT_W'(FRAME_BITS - 1);

    state_t                  state_q,   state_d;
    logic [c_per_w-1:0]      per_cnt_q, per_cnt_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [c_gap_w-1:0]      gap_cnt_q, gap_cnt_d;
    logic [FRAME_BITS-1:0]   shreg_q,   shreg_d;
    logic                    sck_q,     sck_d;
    logic                    mosi_q,    mosi_d;
    logic                    cs_n_q,    cs_n_d;
    logic                    clr_n_q,   clr_n_d;
    logic                    overrun_q, overrun_d;

    logic                    w_tick;
    logic                    w_sck_rise;
    logic                    w_sck_fall;
    logic [DATA_FIELD_BITS-1:0] w_field;
    logic [FRAME_BITS-1:0]   w_frame;

    // Narrow samples sit at the top of the 12-bit field.
    generate
        if (SIZE >= DATA_FIELD_BITS) begin : g_field_full
            assign w_field = data[DATA_FIELD_BITS-1:0];
        end else begin : g_field_pad
            assign w_field = {data, {(DATA_FIELD_BITS - SIZE){1'b0}}};
        end
    endgenerate

    assign w_frame = {8'h00, DAC_CMD, DAC_ADDR, w_field, 4'h0};
    assign w_tick  = enable && (per_cnt_q == '0);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_spi_clk_div (
        .clk  (clk),
        .rst  (rst),
        .run  (state_q == ST_SHIFT),
        .rise (w_sck_rise),
        .fall (w_sck_fall)
    );

    always_comb begin
        per_cnt_d = per_cnt_q;
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        shreg_d   = shreg_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        clr_n_d   = 1'b1;
        // A tick that does not find the FSM idle is a lost sample slot.
        overrun_d = overrun_q | (w_tick && (state_q != ST_IDLE));

        if (!enable || (per_cnt_q == c_per_last)) begin
            per_cnt_d = '0;
        end else begin
            per_cnt_d = per_cnt_q + c_per_w'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (w_tick) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shreg_d   = {w_frame[FRAME_BITS-2:0], 1'b0};
                mosi_d    = w_frame[FRAME_BITS-1];
                sck_d     = 1'b0;
                cs_n_d    = 1'b0;
                bit_cnt_d = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_sck_rise) begin
                    sck_d = 1'b1;
                end
                if (w_sck_fall) begin
                    sck_d = 1'b0;
                    if (bit_cnt_q == c_bit_last) begin
                        cs_n_d    = 1'b1;
                        mosi_d    = 1'b0;
                        gap_cnt_d = '0;
                        state_d   = ST_GAP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        mosi_d    = shreg_q[FRAME_BITS-1];
                        shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == c_gap_last) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + c_gap_w'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            per_cnt_q <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            shreg_q   <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            clr_n_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            shreg_q   <= shreg_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            clr_n_q   <= clr_n_d;
            overrun_q <= overrun_d;
        end
    end

    assign next      = (state_q == ST_REQ);
    assign busy      = (state_q != ST_IDLE);
    assign spi_sck   = sck_q;
    assign spi_mosi  = mosi_q;
    assign dac_cs_n  = cs_n_q;
    assign dac_clr_n = clr_n_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire
